spi_controller: RTL and testbench

- SPI bus controller (initiator) in the system `clk` domain; drives `spi_clk`, `spi_cs` and `spi_mosi`, and samples `spi_miso`.
- Mode 0 only: CPOL=0, CPHA=0, MSB first, single-bit SPI.
- Used to exercise or replay traffic against SPI flash and device-side blocks.
- Byte-wide valid/ready transmit interface; receive side is a one-cycle strobe per byte; a last-byte flag ends the chip-select frame.

---
 rtl/spi_controller_if.sv | 25 ++
 rtl/spi_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_controller.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_controller_if.sv
// spi_controller_if: byte-level transmit/receive handshake of spi_controller.
//   tx_valid/tx_data/tx_last : byte offered to the controller (tx_last closes the frame)
//   tx_ready                 : controller accepts the byte this cycle
//   rx_strobe/rx_data        : one-cycle pulse with the byte shifted in from MISO
//   busy                     : controller is not idle
// Modports: master = the client feeding bytes, slave = the controller.
interface spi_controller_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_strobe;
  logic [7:0] rx_data;
  logic       busy;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_strobe, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_strobe, rx_data, busy
  );
endinterface

// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 (CPOL=0, CPHA=0, MSB first) initiator.
//   clk, reset     : system clock, synchronous active-high reset
//   bus (slave)    : tx_valid/tx_data/tx_last/tx_ready in, rx_strobe/rx_data/busy out
//   spi_clk/spi_cs/spi_mosi : serial bus outputs (all registered)
//   spi_miso       : serial data in
// Optional: define SPI_CONTROLLER_MISO_SYNC_EN to pass spi_miso through a
// two-flop synchroniser ahead of the sample point (requires CLK_DIV >= 3).
module spi_controller #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic            clk,
  input  logic            reset,
  spi_controller_if.slave bus,
  output logic            spi_clk,
  output logic            spi_cs,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  localparam int unsigned DW   = $clog2(CLK_DIV + 1);
  localparam int unsigned TMAX = (CS_SETUP > CS_HOLD)
                                 ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                 : ((CS_HOLD  > CS_IDLE) ? CS_HOLD  : CS_IDLE);
  localparam int unsigned TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

  localparam logic [DW-1:0] DIV_LOAD   = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] SETUP_LOAD = TW'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'((CS_HOLD  > 0) ? CS_HOLD  - 1 : 0);
  // The IDLE cycle in which the next byte is accepted counts toward the
  // minimum CS-high time, so GAP itself is one cycle shorter than CS_IDLE.
  localparam logic [TW-1:0] GAP_LOAD   = TW'((CS_IDLE > 1) ? CS_IDLE - 2 : 0);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOW, HIGH, WAIT, HOLD, GAP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          last_q, last_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic          strobe_q, strobe_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          accept;
  logic          miso_smp;

`ifdef SPI_CONTROLLER_MISO_SYNC_EN
  logic miso_s1_q, miso_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
    end
  end

  assign miso_smp = miso_s2_q;

  if (CLK_DIV < 3) begin : g_clk_div_check
    $error("spi_controller: CLK_DIV must be >= 3 with the MISO synchroniser");
  end
`else
  assign miso_smp = spi_miso;
`endif

  assign accept = bus.tx_valid & ready_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    tmr_d     = tmr_q;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    last_d    = last_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    strobe_d  = 1'b0;
    rx_data_d = rx_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          tmr_d   = SETUP_LOAD;
          cs_d    = 1'b0;
          tx_sh_d = bus.tx_data;
          mosi_d  = bus.tx_data[7];
          last_d  = bus.tx_last;
          bit_d   = 3'd7;
        end
      end
      SETUP: begin
        if (tmr_q == '0) begin
          state_d = LOW;
          div_d   = DIV_LOAD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      LOW: begin
        if (div_q == '0) begin
          state_d = HIGH;
          div_d   = DIV_LOAD;
          sclk_d  = 1'b1;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      HIGH: begin
        if (div_q == '0) begin
          sclk_d  = 1'b0;
          rx_sh_d = {rx_sh_q[6:0], miso_smp};
          if (bit_q != 3'd0) begin
            // Next bit goes out on the same edge that drops spi_clk.
            state_d = LOW;
            div_d   = DIV_LOAD;
            bit_d   = bit_q - 1'b1;
            mosi_d  = tx_sh_q[6];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end else begin
            strobe_d  = 1'b1;
            rx_data_d = rx_sh_d;
            if (last_q) begin
              state_d = HOLD;
              tmr_d   = HOLD_LOAD;
            end else begin
              state_d = WAIT;
            end
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      WAIT: begin
        if (accept) begin
          state_d = LOW;
          div_d   = DIV_LOAD;
          tx_sh_d = bus.tx_data;
          mosi_d  = bus.tx_data[7];
          last_d  = bus.tx_last;
          bit_d   = 3'd7;
        end
      end
      HOLD: begin
        if (tmr_q == '0) begin
          state_d = GAP;
          tmr_d   = GAP_LOAD;
          cs_d    = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == WAIT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      tmr_q     <= '0;
      bit_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      last_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      strobe_q  <= 1'b0;
      rx_data_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      last_q    <= last_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      strobe_q  <= strobe_d;
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign spi_clk       = sclk_q;
  assign spi_cs        = cs_q;
  assign spi_mosi      = mosi_q;
  assign bus.tx_ready  = ready_q;
  assign bus.rx_strobe = strobe_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: randomized bench for spi_controller with a mode-0 SPI
// device model, a byte scoreboard and bus-timing checks.
module tb_spi_controller;
  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned CS_IDLE  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_clk, spi_cs, spi_mosi;
  logic spi_miso;

  spi_controller_if bus_if ();

  spi_controller #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_IDLE (CS_IDLE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .spi_clk (spi_clk),
    .spi_cs  (spi_cs),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues, filled by the driver at byte acceptance.
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  int         exp_low_q[$];      // spi_clk-low cycles before each byte's first rise
  int         frame_rises_q[$];  // spi_clk pulses per completed frame
  int         exp_cs_high = -1;  // exact CS-high cycles before this frame, or -1

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected at %0t", name, $time);
  endtask

  // SPI device model: presents the response MSB first, advancing on each
  // spi_clk fall; restarts at bit 7 whenever chip select is released.
  logic [7:0] cur_resp = '0;
  logic [2:0] sl_falls = '0;

  always @(negedge spi_clk or posedge spi_cs) begin
    if (spi_cs) sl_falls <= '0;
    else        sl_falls <= sl_falls + 3'd1;
  end

  assign spi_miso = cur_resp[~sl_falls];  // bit (7 - falls)

  // Bus monitor: sampled mid-cycle.
  logic       prev_clk = 1'b0;
  logic       prev_cs  = 1'b1;
  logic       frame_end = 1'b0;
  int         lo_cnt = 0, hi_cnt = 0, cs_hi_cnt = 0, nrise = 0, frise = 0;
  logic [7:0] mosi_acc = '0;

  always @(negedge clk) begin
    if (reset) begin
      exp_tx_q.delete();
      exp_rx_q.delete();
      exp_low_q.delete();
      frame_rises_q.delete();
      prev_clk  = 1'b0;
      prev_cs   = 1'b1;
      frame_end = 1'b0;
      lo_cnt = 0; hi_cnt = 0; cs_hi_cnt = 0; nrise = 0; frise = 0;
    end else begin
      logic fall_now;
      fall_now = prev_clk && !spi_clk;

      if (prev_cs && !spi_cs) begin
        if (frame_end) begin
          if (exp_cs_high >= 0) chk("cs_high_gap", cs_hi_cnt, exp_cs_high);
          else                  chk("cs_high_min", int'(cs_hi_cnt >= CS_IDLE), 1);
        end
        lo_cnt = 0; nrise = 0; frise = 0;
      end

      if (!prev_cs && spi_cs) begin
        chk("cs_hold", lo_cnt, CS_HOLD);
        if (frame_rises_q.size() == 0) fail("frame_unexpected_end");
        else chk("frame_pulses", frise, frame_rises_q.pop_front());
        frame_end = 1'b1;
        cs_hi_cnt = 0;
      end

      if (spi_cs && spi_clk) fail("clk_high_outside_cs");

      if (!prev_clk && spi_clk) begin
        if (nrise == 0) begin
          if (exp_low_q.size() == 0) fail("low_q_empty");
          else chk("low_before_byte", lo_cnt, exp_low_q.pop_front());
        end else begin
          chk("low_in_byte", lo_cnt, CLK_DIV);
        end
        mosi_acc = {mosi_acc[6:0], spi_mosi};
        nrise++;
        frise++;
        hi_cnt = 0;
        if (nrise == 8) begin
          if (exp_tx_q.size() == 0) fail("tx_q_empty");
          else chk("mosi_byte", mosi_acc, exp_tx_q.pop_front());
        end
      end

      if (fall_now) begin
        chk("clk_high", hi_cnt, CLK_DIV);
        lo_cnt = 0;
        if (nrise == 8) begin
          chk("rx_strobe_at_byte_end", bus_if.rx_strobe, 1);
          if (exp_rx_q.size() == 0) fail("rx_q_empty");
          else chk("rx_data", bus_if.rx_data, exp_rx_q.pop_front());
          nrise = 0;
        end else if (bus_if.rx_strobe) begin
          fail("rx_strobe_mid_byte");
        end
      end else if (bus_if.rx_strobe) begin
        fail("rx_strobe_stray");
      end

      if (spi_clk)      hi_cnt++;
      else if (!spi_cs) lo_cnt++;
      if (spi_cs) cs_hi_cnt++;

      if (spi_cs && frame_end && cs_hi_cnt < CS_IDLE)
        chk("ready_in_gap", bus_if.tx_ready, 0);

      prev_clk = spi_clk;
      prev_cs  = spi_cs;
    end
  end

  // Driver: all inputs change 1 time unit after the rising edge.
  int   frame_bytes = 0;
  logic contiguous  = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input int gap,
                      input logic [7:0] resp);
    int n;
    n = 0;
    while (!bus_if.tx_ready) begin
      step();
      n++;
      if (n > 2000) begin
        fail("tx_ready_timeout");
        return;
      end
    end
    repeat (gap) step();
    bus_if.tx_valid = 1'b1;
    bus_if.tx_data  = d;
    bus_if.tx_last  = last;
    step();
    bus_if.tx_valid = 1'b0;
    bus_if.tx_data  = ~d;      // must have been latched at accept
    bus_if.tx_last  = ~last;
    chk("ready_after_accept", bus_if.tx_ready, 0);
    chk("busy_after_accept", bus_if.busy, 1);
    cur_resp = resp;
    exp_tx_q.push_back(d);
    exp_rx_q.push_back(resp);
    if (frame_bytes == 0) begin
      exp_low_q.push_back(CS_SETUP + CLK_DIV);
      exp_cs_high = contiguous ? int'(CS_IDLE) + gap : -1;
    end else begin
      exp_low_q.push_back(CLK_DIV + 1 + gap);
    end
    frame_bytes++;
    if (last) begin
      frame_rises_q.push_back(frame_bytes * 8);
      frame_bytes = 0;
    end
    contiguous = last;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus_if.busy) begin
      step();
      n++;
      if (n > 2000) begin
        fail("busy_timeout");
        break;
      end
    end
    contiguous = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.tx_valid = 1'b0;
    bus_if.tx_data  = '0;
    bus_if.tx_last  = 1'b0;

    // Reset and idle
    reset = 1'b1;
    repeat (3) step();
    chk("ready_in_reset", bus_if.tx_ready, 0);
    reset = 1'b0;
    step();
    chk("ready_after_reset", bus_if.tx_ready, 1);
    chk("rx_data_after_reset", bus_if.rx_data, 0);
    for (int i = 0; i < 20; i++) begin
      chk("idle_cs_clk_mosi_busy", {spi_cs, spi_clk, spi_mosi, bus_if.busy}, 4'b1000);
      step();
    end

    // Single-byte frame, then an immediately following three-byte frame
    send(8'hA5, 1'b1, 0, 8'h3C);
    send(8'h03, 1'b0, 0, 8'($urandom));
    send(8'h00, 1'b0, 0, 8'($urandom));
    send(8'h10, 1'b1, 0, 8'($urandom));

    // Inter-byte stall of 50 cycles
    send(8'h9F, 1'b0, 0, 8'($urandom));
    send(8'h00, 1'b1, 50, 8'($urandom));
    wait_idle();
    repeat (5) step();

    // Reset during the 5th bit
    send(8'h5A, 1'b0, 0, 8'($urandom));
    repeat (38) step();
    chk("in_5th_bit_high", spi_clk, 1);
    reset = 1'b1;
    step();
    chk("reset_outputs", {spi_cs, spi_clk, spi_mosi, bus_if.rx_strobe, bus_if.busy, bus_if.tx_ready},
        6'b100000);
    chk("reset_rx_data", bus_if.rx_data, 0);
    reset = 1'b0;
    frame_bytes = 0;
    contiguous  = 1'b0;
    step();
    send(8'hFF, 1'b1, 0, 8'($urandom));

    // Random frames
    for (int f = 0; f < 15; f++) begin
      int nb;
      nb = int'($urandom_range(1, 4));
      for (int b = 0; b < nb; b++)
        send(8'($urandom), (b == nb - 1), int'($urandom_range(0, 3)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 6)) step();
      end
    end

    wait_idle();
    repeat (10) step();
    chk("queues_drained",
        exp_tx_q.size() + exp_rx_q.size() + exp_low_q.size() + frame_rises_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
